debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for the board's push-buttons and switches. It synchronises N asynchronous inputs and debounces each one against a shared sample-tick prescaler. Each channel produces a clean level, a one-cycle press pulse, a one-cycle release pulse and an optional auto-repeat pulse. It sits between the board pins and the game/control FSMs, and replaces per-button single-channel debouncers.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 105 ++++++++++
 rtl/debounce_bank.sv | 61 ++++++
 tb/tb_debounce_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
// Holds clog2 and the default tick divisor / repeat timing.
package debounce_pkg;

  localparam int BOARD_CLK_HZ = 2_500_000;
  localparam int SAMPLE_HZ    = 1_000;
  localparam int DEF_TICK_DIV = BOARD_CLK_HZ / SAMPLE_HZ;
  localparam int DEF_STABLE   = 10;
  localparam int DEF_RPT_DLY  = 200;
  localparam int DEF_RPT_PER  = 50;

  // Ceil log2, never below 1 so it is always a legal width.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter, edge pulses, repeat.
// Ports: clk, rst_n, i_tick, i_in -> o_level, o_press, o_release, o_repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS  = DEF_STABLE,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_RPT_DLY,
  parameter int REPEAT_PERIOD = DEF_RPT_PER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_in,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CW   = clog2(STABLE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = clog2(RMAX + 1);

  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [RW-1:0]          r_rcnt;
  logic                   r_first;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;

  logic          w_s;
  logic          w_commit;
  logic [RW-1:0] w_rnext;
  logic [RW-1:0] w_rthr;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_commit = (w_s != r_level) && i_tick && (r_cnt == C_LAST);
  assign w_rnext  = r_rcnt + 1'b1;
  assign w_rthr   = r_first ? R_DLY : R_PER;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_rcnt    <= '0;
      r_first   <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;

      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_commit) begin
          r_level   <= w_s;
          r_cnt     <= '0;
          r_press   <= w_s;
          r_release <= ~w_s;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // A release commit wins over a repeat due on the same tick.
      if (REPEAT_EN != 0) begin
        if (w_commit && w_s) begin
          r_rcnt  <= '0;
          r_first <= 1'b1;
        end else if (!r_level || w_commit) begin
          r_rcnt  <= '0;
          r_first <= 1'b0;
        end else if (i_tick) begin
          if (w_rnext == w_rthr) begin
            r_repeat <= 1'b1;
            r_rcnt   <= '0;
            r_first  <= 1'b0;
          end else begin
            r_rcnt <= w_rnext;
          end
        end
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer with a shared sample-tick prescaler.
// Ports: clk, rst_n, i_async_in -> o_level, o_press, o_release, o_repeat.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int STABLE_TICKS  = DEF_STABLE,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_RPT_DLY,
  parameter int REPEAT_PERIOD = DEF_RPT_PER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_async_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_repeat
);

  localparam int PW = clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  // With TICK_DIV=1 the counter sits at 0 == P_LAST: tick every cycle.
  assign w_tick = (r_pcnt == P_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_tick   (w_tick),
      .i_in     (i_async_in[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_repeat (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random inputs,
// all compared against a tick-arithmetic reference model.
module tb_debounce_bank;

  localparam int NC = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RP = 2;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] i_async_in;
  logic [NC-1:0] o_level;
  logic [NC-1:0] o_press;
  logic [NC-1:0] o_release;
  logic [NC-1:0] o_repeat;

  debounce_bank #(
    .N_CH         (NC),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .SYNC_STAGES  (2),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_async_in(i_async_in),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_repeat  (o_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int            c;
  int            mlev   [NC];
  int            since  [NC];
  int            pstart [NC];
  logic [NC-1:0] h1;
  logic [NC-1:0] h2;
  logic [NC-1:0] e_lev;
  logic [NC-1:0] e_prs;
  logic [NC-1:0] e_rel;
  logic [NC-1:0] e_rep;
  logic [NC-1:0] seen;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Commit when STABLE ticks have elapsed since s began to disagree;
  // repeats fall on tick RD, RD+RP, RD+2RP... counted from the press.
  task automatic model_step(input logic [NC-1:0] in, input logic rst);
    logic tick;
    logic s;
    int   nt;
    int   m;
    e_prs = '0;
    e_rel = '0;
    e_rep = '0;
    if (!rst) begin
      for (int ch = 0; ch < NC; ch++) begin
        mlev[ch]   = 0;
        since[ch]  = -1;
        pstart[ch] = -1;
      end
      h1    = '0;
      h2    = '0;
      c     = 0;
      e_lev = '0;
      return;
    end
    tick = ((c % TD) == TD - 1);
    for (int ch = 0; ch < NC; ch++) begin
      s = h2[ch];
      if (int'(s) == mlev[ch]) begin
        since[ch] = -1;
      end else begin
        if (since[ch] < 0) since[ch] = c;
        nt = (c + 1) / TD - since[ch] / TD;
        if (tick && nt >= ST) begin
          if (s) begin
            e_prs[ch]  = 1'b1;
            pstart[ch] = (c + 1) / TD;
          end else begin
            e_rel[ch]  = 1'b1;
            pstart[ch] = -1;
          end
          mlev[ch]  = int'(s);
          since[ch] = -1;
          continue;
        end
      end
      if (mlev[ch] == 0) begin
        pstart[ch] = -1;
      end else if (tick && pstart[ch] >= 0) begin
        m = (c + 1) / TD - pstart[ch];
        if (m >= RD && ((m - RD) % RP) == 0) e_rep[ch] = 1'b1;
      end
    end
    h2 = h1;
    h1 = in;
    c++;
    for (int ch = 0; ch < NC; ch++) e_lev[ch] = (mlev[ch] != 0);
  endtask

  task automatic step(input logic [NC-1:0] in, input logic rst);
    @(negedge clk);
    i_async_in = in;
    rst_n      = rst;
    @(posedge clk);
    model_step(in, rst);
    #1;
    check("level", 32'(o_level), 32'(e_lev));
    check("press", 32'(o_press), 32'(e_prs));
    check("release", 32'(o_release), 32'(e_rel));
    check("repeat", 32'(o_repeat), 32'(e_rep));
    seen = seen | o_press | o_release | o_repeat;
  endtask

  task automatic idle(input logic [NC-1:0] in, input int k);
    for (int i = 0; i < k; i++) step(in, 1'b1);
  endtask

  // kind: 0 press, 1 release, 2 repeat. n = steps taken, -1 on timeout.
  task automatic run_until(input logic [NC-1:0] in, input int kind,
                           input int ch, input int lim, output int n);
    logic [NC-1:0] v;
    v = '0;
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      step(in, 1'b1);
      v = (kind == 0) ? o_press : (kind == 1) ? o_release : o_repeat;
      if (v[ch]) begin
        n = k;
        break;
      end
    end
    check("wait_hit", 32'(v[ch]), 32'd1);
  endtask

  int n;

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    seen       = '0;
    rst_n      = 1'b0;
    i_async_in = '0;
    c          = 0;

    step('0, 1'b0);
    step('0, 1'b0);
    check("rst_all", 32'({o_level, o_press, o_release, o_repeat}), 32'd0);
    idle('0, 6);

    run_until(4'b0001, 0, 0, 30, n);
    check("s1_lat", 32'(n >= 11 && n <= 14), 32'd1);
    run_until(4'b0000, 1, 0, 30, n);
    idle('0, 10);

    seen = '0;
    idle(4'b0010, 5);
    idle(4'b0000, 3);
    check("s2_quiet", 32'(seen), 32'd0);
    run_until(4'b0010, 0, 1, 30, n);
    check("s2_lat", 32'(n >= 11 && n <= 14), 32'd1);
    run_until(4'b0000, 1, 1, 30, n);
    idle('0, 10);

    run_until(4'b0100, 0, 2, 30, n);
    run_until(4'b0100, 2, 2, 40, n);
    check("s3_first", 32'(n), 32'd20);
    run_until(4'b0100, 2, 2, 20, n);
    check("s3_per1", 32'(n), 32'd8);
    run_until(4'b0100, 2, 2, 20, n);
    check("s3_per2", 32'(n), 32'd8);
    run_until(4'b0000, 1, 2, 30, n);
    seen = '0;
    idle('0, 40);
    check("s3_stop", 32'(seen), 32'd0);

    run_until(4'b1111, 0, 0, 30, n);
    check("s4_all", 32'(o_press), 32'hF);
    run_until(4'b0000, 1, 0, 30, n);
    idle('0, 10);

    run_until(4'b1000, 0, 3, 30, n);
    idle(4'b1000, 10);
    step(4'b1000, 1'b0);
    check("s5_lvl", 32'(o_level), 32'd0);
    check("s5_rel", 32'(o_release), 32'd0);
    run_until(4'b1000, 0, 3, 30, n);
    check("s5_lat", 32'(n >= 11 && n <= 14), 32'd1);
    run_until(4'b0000, 1, 3, 30, n);
    idle('0, 10);

    seen = '0;
    step(4'b0001, 1'b1);
    idle('0, 20);
    idle(4'b0001, 7);
    idle('0, 30);
    check("s6_quiet", 32'(seen), 32'd0);
    check("s6_lvl", 32'(o_level[0]), 32'd0);

    begin
      logic [NC-1:0] r;
      r = '0;
      for (int i = 0; i < 1500; i++) begin
        for (int ch = 0; ch < NC; ch++)
          if ($urandom_range(13, 0) == 0) r[ch] = ~r[ch];
        step(r, (i == 700) ? 1'b0 : 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
